instr_stream_loader: RTL and testbench

//  Parametrised instruction loader. Takes the byte stream from the UART receiver and packs it MSB-first

---
 rtl/instr_loader_pkg.sv | 13 +
 rtl/instr_loader_ram.sv | 40 ++++
 rtl/instr_stream_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_instr_stream_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction stream loader: FSM state encoding
// and the byte width of the incoming UART stream.
package instr_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_loader_ram.sv
// Simple dual-port instruction memory: one write port and one registered
// read port. A read and a write to the same address in the same cycle
// return the old contents (read-first). Only the read register is reset.
// The memory array itself is never cleared.
module instr_loader_ram #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rd_data;

  // Write port: store one packed instruction word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered output, sees the pre-write contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= {INSTR_W{1'b0}};
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_stream_loader.sv
// Instruction stream loader. Packs UART bytes MSB-first into instruction
// words and writes them in order into an internal memory. The load ends
// when the stream goes idle or the memory fills. The fetch stage reads
// the memory through a registered port.
// Optional feature macro: INSTR_LOADER_LEN_HDR_EN. When it is defined, the
// first byte of a load is a word count, and a short load sets o_len_err.
module instr_stream_loader
  import instr_loader_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int DEPTH       = 256,
  parameter int IDLE_CYCLES = 50000,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data,
  output logic               o_load_done,
  output logic [ADDR_W-1:0]  o_max_addr,
  output logic [ADDR_W:0]    o_word_count,
  output logic               o_overflow,
  output logic               o_len_err
);

  localparam int BPW    = INSTR_W / BYTE_W;
  localparam int BCNT_W = 3;
  localparam int IDLE_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(BPW - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  state_t r_state;
  state_t w_next_state;

  logic [INSTR_W-1:0]        r_shift;
  logic [INSTR_W+BYTE_W-1:0] w_shift_cat;
  logic [BCNT_W-1:0]         r_byte_cnt;
  logic                      r_wr_pend;
  logic [ADDR_W-1:0]         r_wr_ptr;
  logic [ADDR_W-1:0]         r_max_addr;
  logic [CNT_W-1:0]          r_word_count;
  logic [CNT_W-1:0]          w_count_inc;
  logic [IDLE_W-1:0]         r_idle_cnt;
  logic                      r_load_done;
  logic                      r_overflow;

  logic w_accept;
  logic w_hdr_mode;
  logic w_hdr_byte;
  logic w_word_byte;
  logic w_word_last;
  logic w_do_write;
  logic w_full_hit;
  logic w_len_hit;
  logic w_len_zero;
  logic w_timeout;
  logic w_enter_done;

  // Bytes are accepted in every state but S_DONE. With the header feature,
  // the first byte of a load is a length and is kept out of the packer.
  assign w_accept     = i_byte_valid && (r_state != S_DONE);
  assign w_word_byte  = w_accept && !w_hdr_byte;
  assign w_word_last  = w_word_byte && (r_byte_cnt == LAST_BYTE);
  assign w_shift_cat  = {r_shift, i_byte};

  // A completed word is written one edge after its last byte, and only while loading.
  assign w_do_write   = r_wr_pend && (r_state == S_RECV);
  assign w_count_inc  = r_word_count + CNT_W'(1);
  assign w_full_hit   = w_do_write && (w_count_inc == FULL_COUNT);

  // An incoming byte on the timeout cycle takes priority over the timeout.
  assign w_timeout    = (r_state == S_RECV) && !i_byte_valid && (r_idle_cnt == IDLE_LAST);
  assign w_enter_done = (r_state != S_DONE) && (w_next_state == S_DONE);

`ifdef INSTR_LOADER_LEN_HDR_EN
  logic [BYTE_W-1:0] r_len;
  logic              r_len_err;

  assign w_hdr_mode = 1'b1;
  assign w_hdr_byte = w_accept && (r_state == S_IDLE);
  assign w_len_hit  = w_do_write && (32'(w_count_inc) == 32'(r_len));
  assign w_len_zero = (r_state == S_RECV) && (r_len == 8'd0);

  // Capture the requested word count from the header byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len <= 8'd0;
    end else if (w_hdr_byte) begin
      r_len <= i_byte;
    end else begin
      r_len <= r_len;
    end
  end

  // A timeout in header mode means fewer than N words arrived.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_err <= 1'b0;
    end else if (w_timeout) begin
      r_len_err <= 1'b1;
    end else begin
      r_len_err <= r_len_err;
    end
  end

  assign o_len_err = r_len_err;
`else
  assign w_hdr_mode = 1'b0;
  assign w_hdr_byte = 1'b0;
  assign w_len_hit  = 1'b0;
  assign w_len_zero = 1'b0;
  assign o_len_err  = 1'b0;
`endif

  // Load FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Load FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_RECV;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RECV: begin
        if (w_full_hit || w_len_hit || w_len_zero) begin
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          // With no word stored, the load restarts. In header mode, the length byte already committed the load.
          if ((r_word_count != CNT_W'(0)) || w_hdr_mode) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_RECV;
        end
      end
      S_DONE: begin
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Byte packer: shift bytes in MSB-first and flag a complete word for writing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift    <= {INSTR_W{1'b0}};
      r_byte_cnt <= {BCNT_W{1'b0}};
      r_wr_pend  <= 1'b0;
    end else begin
      if (w_word_byte) begin
        r_shift <= w_shift_cat[INSTR_W-1:0];
      end
      // Leaving S_RECV without a full word drops the partial bytes.
      if (w_next_state != S_RECV) begin
        r_byte_cnt <= {BCNT_W{1'b0}};
      end else if (w_word_last) begin
        r_byte_cnt <= {BCNT_W{1'b0}};
      end else if (w_word_byte) begin
        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
      end
      r_wr_pend <= w_word_last && (w_next_state == S_RECV);
    end
  end

  // Idle counter: restarts on each byte and saturates at the timeout value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idle_cnt <= {IDLE_W{1'b0}};
    end else if (w_accept || (w_next_state != S_RECV)) begin
      r_idle_cnt <= {IDLE_W{1'b0}};
    end else if (r_idle_cnt != IDLE_LAST) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  // Write bookkeeping: pointer (no wrap), last address and word count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= {ADDR_W{1'b0}};
      r_max_addr   <= {ADDR_W{1'b0}};
      r_word_count <= {CNT_W{1'b0}};
    end else if (w_do_write) begin
      r_max_addr   <= r_wr_ptr;
      r_word_count <= w_count_inc;
      if (r_wr_ptr != LAST_ADDR) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
    end
  end

  // Sticky status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_load_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_enter_done) begin
        r_load_done <= 1'b1;
      end
      if (i_byte_valid && (r_state == S_DONE)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_load_done  = r_load_done;
  assign o_max_addr   = r_max_addr;
  assign o_word_count = r_word_count;
  assign o_overflow   = r_overflow;

  instr_loader_ram #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (w_do_write),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (r_shift),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_instr_stream_loader.sv
// Self-checking bench for instr_stream_loader (INSTR_W=16, DEPTH=4, IDLE_CYCLES=20).
// The reference model describes a load in terms of byte lists, completed
// words and idle gaps. Inputs are driven and outputs are sampled on the
// falling clock edge.
module tb_instr_stream_loader;

  localparam int INSTR_W     = 16;
  localparam int DEPTH       = 4;
  localparam int IDLE_CYCLES = 20;
  localparam int ADDR_W      = 2;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_byte_valid = 1'b0;
  logic [7:0]         i_byte = 8'h00;
  logic [ADDR_W-1:0]  i_rd_addr = '0;
  logic [INSTR_W-1:0] o_rd_data;
  logic               o_load_done;
  logic [ADDR_W-1:0]  o_max_addr;
  logic [ADDR_W:0]    o_word_count;
  logic               o_overflow;
  logic               o_len_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  int          m_phase;   // 0 waiting for first byte, 1 loading, 2 finished
  logic [7:0]  m_part[$];
  logic [15:0] m_mem[DEPTH];
  int          m_count;
  int          m_max;
  int          m_gap;
  bit          m_done;
  bit          m_ovf;

  always #5 clk = ~clk;

  instr_stream_loader #(
    .INSTR_W     (INSTR_W),
    .DEPTH       (DEPTH),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_load_done  (o_load_done),
    .o_max_addr   (o_max_addr),
    .o_word_count (o_word_count),
    .o_overflow   (o_overflow),
    .o_len_err    (o_len_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_part.delete();
    m_count = 0;
    m_max   = 0;
    m_gap   = 0;
    m_done  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_phase == 2) begin
      m_ovf = 1'b1;
    end else begin
      m_phase = 1;
      m_gap   = 0;
      m_part.push_back(b);
      if (m_part.size() == 2) begin
        m_mem[m_count] = {m_part[0], m_part[1]};
        m_part.delete();
        m_max = m_count;
        m_count++;
        if (m_count == DEPTH) begin
          m_phase = 2;
          m_done  = 1'b1;
        end
      end
    end
  endtask

  task automatic model_idle_edge();
    m_gap++;
    if ((m_phase == 1) && (m_gap == IDLE_CYCLES)) begin
      m_part.delete();
      if (m_count > 0) begin
        m_phase = 2;
        m_done  = 1'b1;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_idle_edge();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle byte strobe followed by gap idle cycles.
  task automatic send(input logic [7:0] b, input int gap);
    i_byte       = b;
    i_byte_valid = 1'b1;
    @(negedge clk);
    i_byte_valid = 1'b0;
    model_byte(b);
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_data"}, 32'(o_rd_data), 32'd0);
    chk({tag, "_done"}, 32'(o_load_done), 32'd0);
    chk({tag, "_max"}, 32'(o_max_addr), 32'd0);
    chk({tag, "_count"}, 32'(o_word_count), 32'd0);
    chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
    chk({tag, "_len_err"}, 32'(o_len_err), 32'd0);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_done"}, 32'(o_load_done), 32'(m_done));
    chk({tag, "_count"}, 32'(o_word_count), 32'(m_count));
    if (m_count > 0) begin
      chk({tag, "_max"}, 32'(o_max_addr), 32'(m_max));
    end else begin
      chk({tag, "_max"}, 32'(o_max_addr), 32'd0);
    end
    chk({tag, "_ovf"}, 32'(o_overflow), 32'(m_ovf));
    chk({tag, "_len_err"}, 32'(o_len_err), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input int addr);
    i_rd_addr = ADDR_W'(addr);
    tick();
    chk(tag, 32'(o_rd_data), 32'(m_mem[addr]));
  endtask

  initial begin
    logic [7:0] b;
    int nb;
    model_reset();
    @(negedge clk);
    do_reset();
    chk_zero("reset");

`ifdef INSTR_LOADER_LEN_HDR_EN
    // Header of 2 words: the load completes on the second word write.
    send(8'h02, 2);
    send(8'hAA, 2);
    send(8'hBB, 2);
    send(8'hCC, 2);
    send(8'hDD, 0);
    chk("hdr2_pre_done", 32'(o_load_done), 32'd0);
    @(negedge clk);
    chk("hdr2_done", 32'(o_load_done), 32'd1);
    chk("hdr2_count", 32'(o_word_count), 32'd2);
    chk("hdr2_max", 32'(o_max_addr), 32'd1);
    chk("hdr2_len_err", 32'(o_len_err), 32'd0);
    i_rd_addr = 2'd0;
    @(negedge clk);
    chk("hdr2_rd0", 32'(o_rd_data), 32'h0000AABB);
    i_rd_addr = 2'd1;
    @(negedge clk);
    chk("hdr2_rd1", 32'(o_rd_data), 32'h0000CCDD);
    // Header of 3 words with only one word sent before the stream goes idle.
    do_reset();
    chk_zero("hdr3_reset");
    send(8'h03, 2);
    send(8'hAA, 2);
    send(8'hBB, 2);
    repeat (25) @(negedge clk);
    chk("hdr3_done", 32'(o_load_done), 32'd1);
    chk("hdr3_len_err", 32'(o_len_err), 32'd1);
    chk("hdr3_count", 32'(o_word_count), 32'd1);
`else
    // 1: two complete words followed by an idle timeout
    send(8'hA5, 2);
    send(8'h5A, 2);
    send(8'h3C, 2);
    send(8'h2B, 2);
    idle(25);
    chk_outputs("basic");
    rd_chk("basic_rd0", 0);
    rd_chk("basic_rd1", 1);
    chk("basic_rd0_val", 32'(m_mem[0]), 32'h0000A55A);

    // 2: partial trailing byte is discarded
    do_reset();
    send(8'hA5, 2);
    send(8'h5A, 2);
    send(8'h10, 2);
    idle(25);
    chk_outputs("partial");
    rd_chk("partial_rd0", 0);

    // 3: memory fills; bytes after completion set overflow
    do_reset();
    for (int i = 0; i < 7; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, 2);
    end
    b = 8'($urandom_range(0, 255));
    send(b, 0);
    chk("full_pre_done", 32'(o_load_done), 32'd0);
    chk("full_pre_count", 32'(o_word_count), 32'd3);
    tick();
    chk_outputs("full_edge");
    send(8'hEE, 2);
    send(8'h77, 2);
    chk_outputs("full_ovf");
    for (int a = 0; a < DEPTH; a++) begin
      rd_chk("full_rd", a);
    end

    // 4: reset in the middle of a load
    do_reset();
    send(8'h33, 1);
    send(8'h44, 1);
    send(8'h55, 1);
    do_reset();
    chk_zero("midrst");
    send(8'h11, 1);
    send(8'h22, 1);
    idle(25);
    chk_outputs("midrst_load");
    rd_chk("midrst_rd0", 0);

    // 5: byte arriving exactly on the timeout cycle keeps the load going
    do_reset();
    send(8'h11, IDLE_CYCLES - 1);
    chk("tmo_edge_done", 32'(o_load_done), 32'd0);
    send(8'h22, 1);
    chk("tmo_edge_count", 32'(o_word_count), 32'd1);
    chk("tmo_edge_done2", 32'(o_load_done), 32'd0);
    idle(25);
    chk_outputs("tmo_edge");
    rd_chk("tmo_edge_rd0", 0);

    // One cycle more of silence with no word stored: the load restarts.
    do_reset();
    send(8'h77, IDLE_CYCLES);
    chk_outputs("restart");
    send(8'h88, 1);
    send(8'h99, 1);
    idle(25);
    chk_outputs("restart_load");
    rd_chk("restart_rd0", 0);

    // Random sessions against the model
    for (int s = 0; s < 5; s++) begin
      do_reset();
      nb = $urandom_range(3, 10);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom_range(0, 255));
        send(b, $urandom_range(1, 6));
      end
      idle(25);
      chk_outputs("rand");
      for (int a = 0; a < m_count; a++) begin
        rd_chk("rand_rd", a);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
